// File: rtl/hwpe_stream_copy_sink_pkg.sv
// ============================================================================
// Module      : hwpe_stream_package
// Description : Shared types for the HWPE stream copy-network fault checkers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hwpe_stream_package;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FAULT = 2'd2
  } copy_fault_state_t;

  // Bit order matches the {valid, data, strb} cause vector on the ports
  typedef struct packed {
    logic valid;
    logic data;
    logic strb;
  } copy_fault_cause_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_stream_copy_sink_if.sv
// ============================================================================
// Module      : hwpe_stream_intf_stream
// Description : HWPE stream handshake bundle (valid/ready/data/strb).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source  (output valid, output data, output strb, input  ready);
  modport sink    (input  valid, input  data, input  strb, output ready);
  modport monitor (input  valid, input  data, input  strb, input  ready);

endinterface

`default_nettype wire

// File: rtl/hwpe_stream_copy_fault_cnt.sv
// ============================================================================
// Module      : hwpe_stream_copy_fault_cnt
// Description : Saturating fault counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_stream_copy_fault_cnt #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  input  wire logic                 clear_i,
  input  wire logic                 incr_i,
  output logic [CNT_WIDTH-1:0]      count_o
);

  logic [CNT_WIDTH-1:0] r_count;

  // Clear wins over a same-cycle increment; the count holds at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (incr_i && (r_count != {CNT_WIDTH{1'b1}})) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/hwpe_stream_copy_sink.sv
// ============================================================================
// Module      : hwpe_stream_copy_sink
// Description : Consumer-side end of a copy network; forwards ready to the
//               copy stream and flags any divergence from the normal stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_stream_copy_sink
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter bit          COMPARE_IDLE = 1'b0
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_ni,
  input  wire logic                  enable_i,
  input  wire logic                  clear_i,
  hwpe_stream_intf_stream.monitor    normal_i,
  hwpe_stream_intf_stream.sink       copy_i,
  output logic                       fault_detected_o,
  output logic                       fault_sticky_o,
  output logic [2:0]                 fault_cause_o,
  output logic [CNT_WIDTH-1:0]       fault_count_o
);

  localparam int unsigned c_STRB_WIDTH = DATA_WIDTH / 8;

  copy_fault_state_t r_state;
  copy_fault_state_t w_state_next;
  copy_fault_cause_t r_cause;
  copy_fault_cause_t w_cause_next;
  logic              r_detected;

  logic w_cmp;
  logic w_mv;
  logic w_md;
  logic w_ms;
  logic w_mis;
  logic w_cnt_incr;

  // Both networks must see exactly the same backpressure
  assign copy_i.ready = normal_i.ready;

  assign w_cmp = COMPARE_IDLE ? 1'b1 : (normal_i.valid && copy_i.valid);
  assign w_mv  = normal_i.valid != copy_i.valid;
  assign w_md  = w_cmp && (normal_i.data[DATA_WIDTH-1:0] != copy_i.data[DATA_WIDTH-1:0]);
  assign w_ms  = w_cmp && (normal_i.strb[c_STRB_WIDTH-1:0] != copy_i.strb[c_STRB_WIDTH-1:0]);
  assign w_mis = enable_i && (w_mv || w_md || w_ms);

  assign w_cnt_incr = w_mis && ((r_state == CHECK) || (r_state == FAULT));

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    if (clear_i) begin
      w_state_next = enable_i ? CHECK : IDLE;
      w_cause_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable_i) w_state_next = CHECK;
        end
        CHECK: begin
          if (w_mis) begin
            w_state_next = FAULT;
            w_cause_next = '{valid: w_mv, data: w_md, strb: w_ms};
          end else if (!enable_i) begin
            w_state_next = IDLE;
          end
        end
        FAULT: begin
          w_state_next = FAULT;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cause    <= '0;
      r_detected <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cause    <= w_cause_next;
      r_detected <= w_mis;
    end
  end

  hwpe_stream_copy_fault_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) i_fault_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .incr_i  (w_cnt_incr),
    .count_o (fault_count_o)
  );

  assign fault_detected_o = r_detected;
  assign fault_sticky_o   = (r_state == FAULT);
  assign fault_cause_o    = r_cause;

endmodule

`default_nettype wire
